// File: rtl/adder_pkg.sv
// Shared defaults and per-stage control type for the pipelined adder.
package adder_pkg;

  localparam int unsigned ADD_WIDTH_DEF  = 32;
  localparam int unsigned ADD_STAGES_DEF = 4;

  // Control bits that travel alongside each operation through the pipe.
  typedef struct packed {
    logic valid;
    logic sub;
  } stage_ctrl_t;

endpackage

// File: rtl/adder_chunk_stage.sv
// Combinational CHUNK-bit a+b+c slice; also reports the carry into its own MSB
// so the top slice can derive signed overflow.
module adder_chunk_stage
  import adder_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] full;

  always_comb begin
    full     = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
    sum      = full[CHUNK-1:0];
    cout     = full[CHUNK];
    // Sum bit = a ^ b ^ carry-in at that bit, so the MSB carry-in falls out directly.
    c_msb_in = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
  end

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined ripple-carry adder, one CHUNK per stage, global-stall valid/ready.
// Optional subtract mode: define ADDER_SUB_EN to add the sub port.
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = ADD_WIDTH_DEF,
  parameter int unsigned STAGES = ADD_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
`ifdef ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_split
    $error("pipelined_adder_nbit: WIDTH must be a multiple of STAGES");
  end

  logic sub_in;
`ifdef ADDER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Stage registers: operands travel whole, finished chunks accumulate in s_q.
  stage_ctrl_t      ctrl_q [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] s_q    [STAGES];
  logic             c_q    [STAGES];
  logic             ov_q;

  stage_ctrl_t      src_ctrl [STAGES];
  logic [WIDTH-1:0] src_a    [STAGES];
  logic [WIDTH-1:0] src_b    [STAGES];
  logic [WIDTH-1:0] src_s    [STAGES];
  logic             src_c    [STAGES];

  logic [CHUNK-1:0] a_chunk    [STAGES];
  logic [CHUNK-1:0] b_chunk    [STAGES];
  logic [CHUNK-1:0] chunk_sum  [STAGES];
  logic             chunk_cout [STAGES];
  logic             chunk_cmsb [STAGES];
  logic [WIDTH-1:0] new_s      [STAGES];

  logic advance;

  assign out_valid = ctrl_q[STAGES-1].valid;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ov_q;

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        src_ctrl[k].valid = in_valid;
        src_ctrl[k].sub   = sub_in;
        src_a[k]          = a;
        src_b[k]          = b;
        src_s[k]          = '0;
        src_c[k]          = cin ^ sub_in;
      end else begin
        src_ctrl[k] = ctrl_q[k-1];
        src_a[k]    = a_q[k-1];
        src_b[k]    = b_q[k-1];
        src_s[k]    = s_q[k-1];
        src_c[k]    = c_q[k-1];
      end
      // b is inverted chunk-by-chunk using the sub bit that travels with the op.
      a_chunk[k] = src_a[k][k*CHUNK +: CHUNK];
      b_chunk[k] = src_ctrl[k].sub ? ~src_b[k][k*CHUNK +: CHUNK]
                                   :  src_b[k][k*CHUNK +: CHUNK];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk_stage #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a        (a_chunk[k]),
      .b        (b_chunk[k]),
      .c        (src_c[k]),
      .sum      (chunk_sum[k]),
      .cout     (chunk_cout[k]),
      .c_msb_in (chunk_cmsb[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      new_s[k]                    = src_s[k];
      new_s[k][k*CHUNK +: CHUNK]  = chunk_sum[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        s_q[k]    <= '0;
        c_q[k]    <= 1'b0;
      end
      ov_q <= 1'b0;
    end else if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= src_ctrl[k];
        a_q[k]    <= src_a[k];
        b_q[k]    <= src_b[k];
        s_q[k]    <= new_s[k];
        c_q[k]    <= chunk_cout[k];
      end
      ov_q <= chunk_cmsb[STAGES-1] ^ chunk_cout[STAGES-1];
    end
  end

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Self-checking bench for pipelined_adder_nbit (WIDTH=32, STAGES=4).
module tb_pipelined_adder_nbit;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b, sum;
  logic             cin, sub_v;
  logic             out_valid, out_ready;
  logic             cout, overflow;

  always #5 clk = ~clk;

  pipelined_adder_nbit #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
`ifdef ADDER_SUB_EN
    ,
    .sub      (sub_v)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ov;
  } exp_t;

  exp_t        model_q[$];
  exp_t        e_cur;
  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned pop_cnt   = 0;

  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv);
    exp_t             r;
    logic [WIDTH-1:0] bb;
    logic             ci;
    logic [WIDTH:0]   full;
    bb     = sv ? ~bv : bv;
    ci     = cv ^ sv;
    full   = {1'b0, av} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ov   = (av[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != av[WIDTH-1]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Compare process: model queue fed on input transfers, drained on output transfers.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_sum;
  logic             prev_cout, prev_ov;

  always @(negedge clk) begin
    if (rst) begin
      model_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_sum", sum, prev_sum);
        check("stall_cout", cout, prev_cout);
        check("stall_ov", overflow, prev_ov);
      end
      if (out_valid && out_ready) begin
        if (model_q.size() == 0) begin
          total_cnt++;
          $display("FAIL out_valid: got result 0x%0h, want no result in flight", sum);
        end else begin
          e_cur = model_q.pop_front();
          check("sum", sum, e_cur.sum);
          check("cout", cout, e_cur.cout);
          check("overflow", overflow, e_cur.ov);
          pop_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_cout  = cout;
      prev_ov    = overflow;
      if (in_valid && in_ready) model_q.push_back(model(a, b, cin, sub_v));
    end
  end

  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic cv, input logic sv);
    logic        ok;
    int unsigned tries;
    a        = av;
    b        = bv;
    cin      = cv;
    sub_v    = sv;
    in_valid = 1'b1;
    tries    = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 64);
    if (!ok) begin
      total_cnt++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want acceptance", tries);
    end
  endtask

  task automatic run_directed(input string name, input logic [WIDTH-1:0] av,
                              input logic [WIDTH-1:0] bv, input logic cv, input logic sv,
                              input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int unsigned lat;
    send(av, bv, cv, sv);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(STAGES));
    check({name, "_sum"}, sum, es);
    check({name, "_cout"}, cout, ec);
    check({name, "_ov"}, overflow, eo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 time units, want finish");
    $fatal(1);
  end

  initial begin
    int unsigned base;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub_v     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 32'h0);
    check("rst_cout", cout, 1'b0);
    check("rst_ov", overflow, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_directed("wrap",   32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_directed("posovf", 32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_directed("chunkc", 32'h0000_FFFF, 32'h1,         1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0);
    run_directed("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
`ifdef ADDER_SUB_EN
    run_directed("sub",    32'h5,         32'h7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
`endif

    // Back-to-back stream at full rate.
    base = pop_cnt;
    for (int i = 0; i < 100; i++) begin
      logic sv;
`ifdef ADDER_SUB_EN
      sv = 1'($urandom_range(0, 1));
`else
      sv = 1'b0;
`endif
      send($urandom(), $urandom(), 1'($urandom_range(0, 1)), sv);
    end
    in_valid = 1'b0;
    repeat (STAGES + 2) @(posedge clk);
    #1;
    check("stream_count", 64'(pop_cnt - base), 64'd100);
    check("stream_drained", 64'(model_q.size()), 64'd0);

    // Fill the pipe against a stalled sink, then hold.
    out_ready = 1'b0;
    base      = pop_cnt;
    for (int i = 0; i < 4; i++) send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'b0);
    a        = 32'h1357_9BDF;
    b        = 32'h2468_ACE0;
    cin      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("full_valid", out_valid, 1'b1);
      check("full_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (STAGES + 2) @(posedge clk);
    #1;
    check("stall_count", 64'(pop_cnt - base), 64'd5);
    check("stall_drained", 64'(model_q.size()), 64'd0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) send($urandom(), $urandom(), 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_sum", sum, 32'h0);
    check("arst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = pop_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("arst_no_stale", 64'(pop_cnt - base), 64'd0);
    run_directed("recover", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
